uart_mmio_fifo: RTL and testbench

Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a programmable baud divider, sticky error flags and a level interrupt. It sits on the core's data bus beside the data memory and replaces the single holding-register UART path. The TX/RX 8N1 serialisers are inside the block, so the core can queue bursts without polling `busy` on every byte.

---
 rtl/uart_mmio_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divider,
// sticky error flags and a registered level interrupt.
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RESET = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

  logic hit, acc_rd, acc_wr;
  logic wr_data, wr_baud, wr_ctrl, rd_data, rd_status;
  logic [15:0] baud_q, baud_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d, frame_err_q, frame_err_d;
  logic        irq_q, irq_d, read_valid_q, read_valid_d;
  logic [31:0] read_data_q, read_data_d, rdata;
  logic [7:0]  rx_cnt8;
  logic        unused_bits;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_full, tx_fifo_empty, tx_push, tx_pop, tx_tick;
  logic          tx_empty, tx_busy;
  uart_st_e      tx_st_q, tx_st_d;
  logic [15:0]   tx_div_q, tx_div_d, tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_full, rx_nonempty, rx_push, rx_pop, rx_ovr_set, frame_set;
  logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_tick, rx_half_hit;
  logic [16:0]   rx_half;
  uart_st_e      rx_st_q, rx_st_d;
  logic [15:0]   rx_div_q, rx_div_d, rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  assign unused_bits = ^{write_data[31:16], write_mask[3:2]};

  assign hit       = (address[31:4] == BASE_ADDR[31:4]);
  assign acc_rd    = hit & read_enable;
  assign acc_wr    = hit & write_enable;
  assign wr_data   = acc_wr & (address[3:0] == 4'h0) & write_mask[0];
  assign wr_baud   = acc_wr & (address[3:0] == 4'h8);
  assign wr_ctrl   = acc_wr & (address[3:0] == 4'hC) & write_mask[0];
  assign rd_data   = acc_rd & (address[3:0] == 4'h0);
  assign rd_status = acc_rd & (address[3:0] == 4'h4);

  // Full/empty come from the pre-edge count so a same-cycle pop never rescues a push.
  assign tx_full       = (tx_cnt_q == FULL_CNT);
  assign tx_fifo_empty = (tx_cnt_q == '0);
  assign tx_push       = wr_data & ~tx_full;
  assign tx_busy       = (tx_st_q != ST_IDLE);
  assign tx_empty      = tx_fifo_empty & ~tx_busy;
  assign tx_tick       = (tx_div_q == tx_baud_q);

  assign rx_full     = (rx_cnt_q == FULL_CNT);
  assign rx_nonempty = (rx_cnt_q != '0);
  assign rx_pop      = rd_data & rx_nonempty;
  assign rx_tick     = (rx_div_q == rx_baud_q);
  assign rx_half     = (17'(rx_baud_q) + 17'd1) >> 1;
  assign rx_half_hit = (17'(rx_div_q) + 17'd1) >= rx_half;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_st_d    = tx_st_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_pop     = 1'b0;
    case (tx_st_q)
      ST_IDLE: if (!tx_fifo_empty) begin
        tx_pop = 1'b1; tx_st_d = ST_START; tx_div_d = '0;
        tx_shift_d = tx_mem[tx_rd_q]; tx_baud_d = baud_q;
      end
      ST_START: if (tx_tick) begin
        tx_div_d = '0; tx_bit_d = '0; tx_st_d = ST_DATA;
      end else tx_div_d = tx_div_q + 16'd1;
      ST_DATA: if (tx_tick) begin
        tx_div_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_st_d = ST_STOP;
        else tx_bit_d = tx_bit_q + 3'd1;
      end else tx_div_d = tx_div_q + 16'd1;
      default: if (tx_tick) begin
        tx_div_d = '0;
        // Chain straight into the next frame so bursts have no idle gap.
        if (!tx_fifo_empty) begin
          tx_pop = 1'b1; tx_st_d = ST_START;
          tx_shift_d = tx_mem[tx_rd_q]; tx_baud_d = baud_q;
        end else tx_st_d = ST_IDLE;
      end else tx_div_d = tx_div_q + 16'd1;
    endcase
    case (tx_st_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_baud_d  = rx_baud_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    frame_set  = 1'b0;
    case (rx_st_q)
      ST_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_st_d = ST_START; rx_div_d = '0; rx_baud_d = baud_q;
      end
      ST_START: if (rx_half_hit) begin
        rx_div_d = '0; rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
      end else rx_div_d = rx_div_q + 16'd1;
      ST_DATA: if (rx_tick) begin
        rx_div_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_div_d = rx_div_q + 16'd1;
      default: if (rx_tick) begin
        rx_div_d = '0; rx_st_d = ST_IDLE;
        if (!rx_s2_q) frame_set = 1'b1;
        else if (rx_full) rx_ovr_set = 1'b1;
        else rx_push = 1'b1;
      end else rx_div_d = rx_div_q + 16'd1;
    endcase
  end

  always_comb begin
    tx_wr_d  = tx_wr_q + AW'(tx_push);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wr_d  = rx_wr_q + AW'(rx_push);
    rx_rd_d  = rx_rd_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    baud_d = baud_q;
    if (wr_baud && write_mask[0]) baud_d[7:0]  = write_data[7:0];
    if (wr_baud && write_mask[1]) baud_d[15:8] = write_data[15:8];
    ctrl_d = wr_ctrl ? write_data[1:0] : ctrl_q;

    // A new event in the same cycle as the clearing read stays visible.
    rx_ovr_d    = (rx_ovr_q & ~rd_status) | rx_ovr_set;
    tx_ovf_d    = (tx_ovf_q & ~rd_status) | (wr_data & tx_full);
    frame_err_d = (frame_err_q & ~rd_status) | frame_set;

    irq_d = (ctrl_q[0] & rx_nonempty) | (ctrl_q[1] & tx_empty);

    rx_cnt8 = 8'(rx_cnt_q);
    case (address[3:0])
      4'h0:    rdata = rx_nonempty ? {24'h0, rx_mem[rx_rd_q]} : 32'h0;
      4'h4:    rdata = {16'h0, rx_cnt8, 1'b0, frame_err_q, tx_ovf_q, rx_ovr_q,
                        tx_busy, tx_empty, tx_full, rx_nonempty};
      4'h8:    rdata = {16'h0, baud_q};
      4'hC:    rdata = {30'h0, ctrl_q};
      default: rdata = 32'h0;
    endcase
    read_data_d  = acc_rd ? rdata : read_data_q;
    read_valid_d = acc_rd;
  end

  // NOTE: FIFO storage is not reset; the pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= write_data[7:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= BAUD_RESET; ctrl_q <= '0;
      rx_ovr_q <= 1'b0; tx_ovf_q <= 1'b0; frame_err_q <= 1'b0;
      irq_q <= 1'b0; read_valid_q <= 1'b0; read_data_q <= '0;
      tx_wr_q <= '0; tx_rd_q <= '0; tx_cnt_q <= '0;
      rx_wr_q <= '0; rx_rd_q <= '0; rx_cnt_q <= '0;
      tx_st_q <= ST_IDLE; tx_div_q <= '0; tx_bit_q <= '0;
      tx_shift_q <= '0; tx_baud_q <= '0; tx_q <= 1'b1;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
      rx_st_q <= ST_IDLE; rx_div_q <= '0; rx_bit_q <= '0;
      rx_shift_q <= '0; rx_baud_q <= '0;
    end else begin
      baud_q <= baud_d; ctrl_q <= ctrl_d;
      rx_ovr_q <= rx_ovr_d; tx_ovf_q <= tx_ovf_d; frame_err_q <= frame_err_d;
      irq_q <= irq_d; read_valid_q <= read_valid_d; read_data_q <= read_data_d;
      tx_wr_q <= tx_wr_d; tx_rd_q <= tx_rd_d; tx_cnt_q <= tx_cnt_d;
      rx_wr_q <= rx_wr_d; rx_rd_q <= rx_rd_d; rx_cnt_q <= rx_cnt_d;
      tx_st_q <= tx_st_d; tx_div_q <= tx_div_d; tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d; tx_baud_q <= tx_baud_d; tx_q <= tx_d;
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      rx_st_q <= rx_st_d; rx_div_q <= rx_div_d; rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d; rx_baud_q <= rx_baud_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign irq        = irq_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register vector table plus hand-written
// TX, loopback, frame-error, overrun, interrupt and reset sequences at BAUD=3.
module tb_uart_mmio_fifo;

  localparam logic [31:0] A_DATA   = 32'h1001_0000;
  localparam logic [31:0] A_STATUS = 32'h1001_0004;
  localparam logic [31:0] A_BAUD   = 32'h1001_0008;
  localparam logic [31:0] A_CTRL   = 32'h1001_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data, read_data;
  logic [3:0]  write_mask;
  logic        write_enable, read_enable, read_valid, irq, tx, rx;
  logic        rx_drv, loop_en;

  int n_cmp  = 0;
  int n_fail = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart_mmio_fifo dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_mask(write_mask), .write_enable(write_enable),
    .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
    .irq(irq), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    address = addr; write_data = data; write_mask = mask; write_enable = 1'b1;
    tick(1);
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    address = addr; read_enable = 1'b1;
    tick(1);
    read_enable = 1'b0;
    check("read_valid", {31'h0, read_valid}, 32'h1);
    d = read_data;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0; tick(4);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i]; tick(4);
    end
    rx_drv = stop_bit; tick(4);
    rx_drv = 1'b1; tick(4);
  endtask

  // Bench-side 8N1 receiver on tx, sampling mid-bit for a 4-clock bit period.
  task automatic decode_tx(output logic [7:0] b, output logic ok);
    ok = 1'b0; b = '0;
    for (int t = 0; t < 200 && tx !== 1'b0; t++) tick(1);
    if (tx !== 1'b0) return;
    tick(2);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      tick(4);
      b[i] = tx;
    end
    tick(4);
    ok = (tx === 1'b1);
  endtask

  function automatic logic [7:0] burst_byte(input int i);
    return 8'(i * 29 + 7);
  endfunction

  function automatic logic [7:0] rx_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  got[17];
    logic        got_ok[17];
    logic        any_low;
    logic [7:0]  b55;
    logic        exp_tx;
    int          idx;

    vecs[0]  = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_0003};
    vecs[1]  = '{1'b0, A_STATUS,     32'h0,         4'h0, 32'h0000_0004};
    vecs[2]  = '{1'b0, A_CTRL,       32'h0,         4'h0, 32'h0000_0000};
    vecs[3]  = '{1'b1, A_BAUD,       32'h0000_1234, 4'h1, 32'h0};
    vecs[4]  = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_0034};
    vecs[5]  = '{1'b1, A_BAUD,       32'h0000_AB00, 4'h2, 32'h0};
    vecs[6]  = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_AB34};
    vecs[7]  = '{1'b1, 32'h1001_0018, 32'h0000_0007, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_AB34};
    vecs[9]  = '{1'b1, A_STATUS,     32'h0000_00FF, 4'hF, 32'h0};
    vecs[10] = '{1'b0, A_STATUS,     32'h0,         4'h0, 32'h0000_0004};
    vecs[11] = '{1'b1, A_CTRL,       32'hFFFF_FFFF, 4'h1, 32'h0};
    vecs[12] = '{1'b0, A_CTRL,       32'h0,         4'h0, 32'h0000_0003};
    vecs[13] = '{1'b1, A_CTRL,       32'hFFFF_FFFC, 4'h1, 32'h0};
    vecs[14] = '{1'b0, A_CTRL,       32'h0,         4'h0, 32'h0000_0000};
    vecs[15] = '{1'b1, A_BAUD,       32'h0000_0003, 4'h3, 32'h0};
    vecs[16] = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_0003};
    vecs[17] = '{1'b1, A_BAUD,       32'h0000_FFFF, 4'h0, 32'h0};
    vecs[18] = '{1'b0, A_BAUD,       32'h0,         4'h0, 32'h0000_0003};
    vecs[19] = '{1'b0, 32'h1001_0001, 32'h0,        4'h0, 32'h0000_0000};

    rst = 1'b1; address = '0; write_data = '0; write_mask = '0;
    write_enable = 1'b0; read_enable = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    tick(2);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_read_valid", {31'h0, read_valid}, 32'h0);
    check("reset_read_data", read_data, 32'h0);
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    address = 32'h1002_0004; read_enable = 1'b1;
    tick(1);
    read_enable = 1'b0;
    check("oow_read_valid", {31'h0, read_valid}, 32'h0);

    // Single frame 0x55: tx falls two edges after the push, 4 clocks per bit.
    b55 = 8'h55;
    bus_write(A_DATA, 32'h55, 4'h1);
    for (int k = 1; k <= 42; k++) begin
      tick(1);
      idx = (k - 2) / 4;
      if (k == 1 || k >= 42) exp_tx = 1'b1;
      else if (idx == 0) exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = b55[idx-1];
      else exp_tx = 1'b1;
      check($sformatf("tx_55_cycle%0d", k), {31'h0, tx}, {31'h0, exp_tx});
    end
    read_check("status_after_55", A_STATUS, 32'h0000_0004);

    // 17-byte burst, then an 18th write into a full FIFO.
    fork
      begin
        for (int i = 0; i < 17; i++) bus_write(A_DATA, {24'h0, burst_byte(i)}, 4'h1);
        read_check("status_burst_full", A_STATUS, 32'h0000_000A);
        bus_write(A_DATA, 32'hEE, 4'h1);
        read_check("status_overflow_set", A_STATUS, 32'h0000_002A);
        read_check("status_overflow_clr", A_STATUS, 32'h0000_000A);
      end
      begin
        for (int i = 0; i < 17; i++) decode_tx(got[i], got_ok[i]);
      end
    join
    for (int i = 0; i < 17; i++)
      check($sformatf("burst_frame%0d", i), {23'h0, got_ok[i], got[i]}, {23'h0, 1'b1, burst_byte(i)});
    any_low = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick(1);
      if (tx !== 1'b1) any_low = 1'b1;
    end
    check("no_extra_frame", {31'h0, any_low}, 32'h0);
    read_check("status_burst_done", A_STATUS, 32'h0000_0004);

    // Loopback of 0xA5.
    loop_en = 1'b1;
    bus_write(A_DATA, 32'hA5, 4'h1);
    tick(50);
    read_check("loop_status", A_STATUS, 32'h0000_0105);
    read_check("loop_data", A_DATA, 32'h0000_00A5);
    read_check("loop_status_after", A_STATUS, 32'h0000_0004);
    read_check("empty_data_read", A_DATA, 32'h0000_0000);
    loop_en = 1'b0;

    // Frame error: stop bit low.
    send_rx(8'h3C, 1'b0);
    read_check("frame_err_set", A_STATUS, 32'h0000_0044);
    read_check("frame_err_clr", A_STATUS, 32'h0000_0004);

    // Fill RX FIFO and overrun it.
    for (int i = 0; i < 17; i++) send_rx(rx_byte(i), 1'b1);
    read_check("rx_overrun_status", A_STATUS, 32'h0000_1015);
    for (int i = 0; i < 16; i++)
      read_check($sformatf("rx_fifo%0d", i), A_DATA, {24'h0, rx_byte(i)});
    read_check("rx_drained_status", A_STATUS, 32'h0000_0004);

    // RX interrupt.
    bus_write(A_CTRL, 32'h1, 4'h1);
    tick(1);
    check("irq_rx_idle", {31'h0, irq}, 32'h0);
    send_rx(8'h11, 1'b1);
    check("irq_rx_rise", {31'h0, irq}, 32'h1);
    send_rx(8'h22, 1'b1);
    read_check("irq_pop1", A_DATA, 32'h11);
    check("irq_after_pop1", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_after_pop1_next", {31'h0, irq}, 32'h1);
    read_check("irq_pop2", A_DATA, 32'h22);
    check("irq_lag_pop2", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_fall", {31'h0, irq}, 32'h0);

    // TX interrupt while idle.
    bus_write(A_CTRL, 32'h2, 4'h1);
    check("irq_tx_lag", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_tx_idle", {31'h0, irq}, 32'h1);
    bus_write(A_CTRL, 32'h0, 4'h1);
    tick(1);
    check("irq_off", {31'h0, irq}, 32'h0);

    // Reset in the middle of a frame forces tx high on the next edge.
    bus_write(A_DATA, 32'h00, 4'h1);
    tick(10);
    check("tx_mid_frame", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    tick(1);
    check("tx_reset_mid_frame", {31'h0, tx}, 32'h1);
    rst = 1'b0;
    any_low = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick(1);
      if (tx !== 1'b1) any_low = 1'b1;
    end
    check("tx_quiet_after_reset", {31'h0, any_low}, 32'h0);
    read_check("status_after_reset", A_STATUS, 32'h0000_0004);
    read_check("baud_after_reset", A_BAUD, 32'h0000_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
